// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared opcode, instruction-field and fetch-queue entry types.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_t;

    // Field bit positions: op[7:6], rs[5:4], rt[3:2], imm[1:0].
    typedef struct packed {
        opcode_t    op;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [1:0] imm;
    } instr_t;

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [7:0] jump_offset(input instr_t i);
        return {{2{i.rs[1]}}, i.rs, i.rt, i.imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Registered synchronous FIFO with flush; head reads 0 when empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : PC sequencer and fetch queue feeding decode; optional jump
//            predecode with halt-on-jump-to-self (FETCH_JUMP_PREDECODE_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         QDEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] Read_Address,
    input  logic [7:0] instruction,
    output logic       Fetch_Valid,
    input  logic       Fetch_Ready,
    output logic [7:0] Fetch_Instr,
    output logic [7:0] Fetch_PC,
    input  logic       Redirect_Valid,
    input  logic [7:0] Redirect_Target,
    output logic       Halted
);

    logic [7:0]   pc;
    logic [7:0]   pc_next;
    fetch_state_t state;
    fetch_state_t state_next;
    fetch_entry_t head;
    logic         full;
    logic         empty;
    logic         deq;
    logic         fetch_go;
    logic         is_jump;
    logic         enq;

    assign deq      = !empty && Fetch_Ready;
    assign fetch_go = (state == ST_RUN) && !Redirect_Valid;
    assign enq      = fetch_go && !is_jump && (!full || deq);

`ifdef FETCH_JUMP_PREDECODE_EN
    instr_t word;
    assign word    = instruction;
    assign is_jump = (word.op == OP_J);
    assign Halted  = (state == ST_HALT);
`else
    assign is_jump = 1'b0;
    assign Halted  = 1'b0;
`endif

    always_comb begin
        pc_next    = pc;
        state_next = state;
        if (Redirect_Valid) begin
            pc_next    = Redirect_Target;
            state_next = ST_RUN;
        end else if (enq) begin
            pc_next = pc + 8'd1;
        end
`ifdef FETCH_JUMP_PREDECODE_EN
        // Jumps are consumed here regardless of queue occupancy.
        else if (fetch_go && is_jump) begin
            pc_next = pc + 8'd1 + jump_offset(word);
            if (jump_offset(word) == 8'hFF) state_next = ST_HALT;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (Redirect_Valid),
        .push      (enq),
        .push_data ({pc, instruction}),
        .pop       (deq),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign Read_Address = pc;
    assign Fetch_Valid  = !empty;
    assign Fetch_PC     = head.pc;
    assign Fetch_Instr  = head.instr;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboarded random/directed bench for instr_fetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam int         QD  = 4;
    localparam logic [7:0] RPC = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Read_Address;
    logic [7:0] instruction;
    logic       Fetch_Valid;
    logic       Fetch_Ready = 1'b0;
    logic [7:0] Fetch_Instr;
    logic [7:0] Fetch_PC;
    logic       Redirect_Valid = 1'b0;
    logic [7:0] Redirect_Target = 8'h00;
    logic       Halted;

    logic [7:0] mem [256];
    assign instruction = mem[Read_Address];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Read_Address    (Read_Address),
        .instruction     (instruction),
        .Fetch_Valid     (Fetch_Valid),
        .Fetch_Ready     (Fetch_Ready),
        .Fetch_Instr     (Fetch_Instr),
        .Fetch_PC        (Fetch_PC),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Halted          (Halted)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ins;
    } exp_t;

    exp_t       sbq[$];
    int         m_cnt;
    logic [7:0] m_pc;
    bit         m_halt;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: compares the presented head against the scoreboard front.
    always @(negedge clk) begin
        check("read_address", Read_Address, m_pc);
        check("halted", Halted, m_halt);
        check("fetch_valid", Fetch_Valid, m_cnt > 0);
        if (!rst_n) begin
            check("reset_fetch_pc", Fetch_PC, 8'h00);
            check("reset_fetch_instr", Fetch_Instr, 8'h00);
        end
        if (Fetch_Valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_head actual_pc=%0h required=none", Fetch_PC);
            end else begin
                check("fetch_pc", Fetch_PC, sbq[0].pc);
                check("fetch_instr", Fetch_Instr, sbq[0].ins);
                if (Fetch_Ready) void'(sbq.pop_front());
            end
        end
    end

    // Reference model: applies one clock edge of the fetch rules.
    task automatic step_model();
        bit         deq   = (m_cnt > 0) && Fetch_Ready;
        bit         space = (m_cnt < QD) || deq;
        logic [7:0] w     = mem[m_pc];
        logic [7:0] nxt;
        if (Redirect_Valid) begin
            sbq.delete();
            m_cnt  = 0;
            m_pc   = Redirect_Target;
            m_halt = 1'b0;
        end else begin
            if (deq) m_cnt--;
            if (!m_halt) begin
`ifdef FETCH_JUMP_PREDECODE_EN
                if (w[7:6] == 2'b11) begin
                    nxt = m_pc + 8'd1 + {{2{w[5]}}, w[5:0]};
                    if (nxt == m_pc) m_halt = 1'b1;
                    m_pc = nxt;
                end else
`endif
                if (space) begin
                    sbq.push_back('{pc: m_pc, ins: w});
                    m_cnt++;
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    endtask

    task automatic cycle(input bit rdy, input bit rv, input logic [7:0] tgt);
        bit live;
        @(posedge clk);
        live = rst_n;
        #1;
        if (live) step_model();
        Fetch_Ready     = rdy;
        Redirect_Valid  = rv;
        Redirect_Target = tgt;
    endtask

    task automatic model_reset();
        sbq.delete();
        m_cnt  = 0;
        m_pc   = RPC;
        m_halt = 1'b0;
    endtask

    initial begin
        for (int n = 0; n < 256; n++) mem[n] = 8'h40 | (n[7:0] & 8'h3F);
        model_reset();

        repeat (3) @(posedge clk);
        #3;
        check("rst_valid", Fetch_Valid, 1'b0);
        check("rst_addr", Read_Address, RPC);
        Fetch_Ready = 1'b1;
        rst_n = 1'b1;

        // Streaming with ready held high, then a redirect near the PC wrap.
        repeat (20) cycle(1, 0, 8'h00);
        cycle(1, 1, 8'hFC);
        repeat (10) cycle(1, 0, 8'h00);

        // Decode stall fills the queue, then drains in order.
        cycle(1, 1, 8'h00);
        repeat (10) cycle(0, 0, 8'h00);
        repeat (10) cycle(1, 0, 8'h00);

        // Full queue with simultaneous ready and redirect.
        repeat (6) cycle(0, 0, 8'h00);
        cycle(1, 1, 8'h20);
        repeat (6) cycle(1, 0, 8'h00);

        // Jump at PC 1 and jump-to-self at PC 5, then redirect out of it.
        mem[1] = 8'hC1;
        mem[5] = 8'hFF;
        cycle(1, 1, 8'h00);
        repeat (15) cycle(1, 0, 8'h00);
        cycle(1, 1, 8'h10);
        repeat (10) cycle(1, 0, 8'h00);

        // Random memory image and random ready/redirect traffic.
        for (int n = 0; n < 256; n++) mem[n] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  8'($urandom_range(0, 255)));

        // Asynchronous reset in the middle of a stall.
        cycle(1, 1, 8'h00);
        repeat (4) cycle(0, 0, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", Fetch_Valid, 1'b0);
        check("async_rst_pc", Fetch_PC, 8'h00);
        check("async_rst_instr", Fetch_Instr, 8'h00);
        check("async_rst_addr", Read_Address, RPC);
        check("async_rst_halted", Halted, 1'b0);
        model_reset();
        Fetch_Ready = 1'b1;
        #2;
        rst_n = 1'b1;
        repeat (12) cycle(1, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 4: fetch queue entries, power of two, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Read_Address  output  8  current PC, presented to instruction memory.
REQ-006 instruction  input  8  memory word at Read_Address, combinational return in the same cycle.
REQ-007 Fetch_Valid  output  1  queue head holds a valid instruction.
REQ-008 Fetch_Ready  input  1  decode accepts the head this cycle.
REQ-009 Fetch_Instr  output  8  head instruction.
REQ-010 Fetch_PC  output  8  address the head instruction was fetched from.
REQ-011 Redirect_Valid  input  1  execute-stage PC redirect request.
REQ-012 Redirect_Target  input  8  new PC for the redirect.
REQ-013 Halted  output  1  fetch stopped on a jump-to-self.

Function
REQ-014 Instruction format SHALL be {op[7:6], rs[5:4], rt[3:2], imm[1:0]}; jump (op=2'b11) offset SHALL be instr[5:0] sign-extended to 8 bits.
REQ-015 Enqueue SHALL occur in a cycle when !Halted, !Redirect_Valid, and the queue is not full or a dequeue occurs in the same cycle; the entry captured is {Read_Address, instruction}.
REQ-016 On enqueue of a non-jump, PC SHALL advance to PC+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-017 PC SHALL hold, and memory SHALL be re-read, while the queue is full with no dequeue.
REQ-018 Dequeue SHALL occur when Fetch_Valid && Fetch_Ready; Fetch_Valid = queue not empty.
REQ-019 Fetch_Instr and Fetch_PC SHALL remain stable while Fetch_Valid=1 and Fetch_Ready=0.
REQ-020 Latency: an enqueued instruction SHALL appear at the head no earlier than the cycle after capture (registered queue, no bypass).
REQ-021 Simultaneous enqueue and dequeue on a full queue SHALL keep occupancy at QDEPTH with no loss.
REQ-022 Redirect_Valid SHALL win over all other events: queue flushed (including any same-cycle dequeue), PC <= Redirect_Target, Halted cleared; Fetch_Valid=0 in the following cycle.
REQ-023 Control FSM states: RUN (fetching), HALT (jump-to-self seen); RUN->HALT on a predecoded jump with offset 6'h3F; HALT->RUN only on Redirect_Valid; Halted=1 exactly in HALT.
REQ-024 In HALT, the queue SHALL continue draining to decode; no new enqueue occurs.

Reset
REQ-025 While rst_n=0: PC=RESET_PC, queue empty, Fetch_Valid=0, Fetch_Instr=8'h00, Fetch_PC=8'h00, Halted=0, state RUN.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronously); the first enqueue occurs on the first rising edge after deassertion.

Configuration
REQ-027 Macro FETCH_JUMP_PREDECODE_EN defined: a jump at PC is consumed by fetch, not enqueued, and PC <= PC+1+sext(offset) modulo 256 in the same cycle; HALT state enabled.
REQ-028 Macro FETCH_JUMP_PREDECODE_EN undefined: jumps are enqueued like any instruction with PC <= PC+1; the HALT state is never entered and Halted is tied to 0; redirection occurs only via Redirect_Valid.

Structure
REQ-029 Shared package fetch_pkg SHALL hold the opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11, the field bit positions, and the {pc, instr} queue-entry typedef.
REQ-030 The queue SHALL be a sub-module fetch_queue: synchronous FIFO, width 16, depth QDEPTH, with a flush input, async active-low reset, and full/empty outputs.

Verification
REQ-031 Reset, Fetch_Ready=1, memory word at addr n = 8'h40|n -> Fetch_PC sequence 0,1,2,... one per cycle, starting the cycle after the first post-reset edge.
REQ-032 Fetch_Ready=0 for 10 cycles, QDEPTH=4 -> four entries (PC 0..3) held, Read_Address stuck at 4; Ready=1 -> PCs 0,1,2,3,4 delivered in order with no gaps.
REQ-033 With the macro, memory[1]=8'hC1 -> Fetch_PC sequence 0,3,4 and the jump is never presented; without the macro -> 0,1,2 with Fetch_Instr=8'hC1 at PC 1.
REQ-034 With the macro, memory[5]=8'hFF -> Halted=1, Read_Address=5, no further enqueues; Redirect_Valid with target 8'h10 -> Halted=0 and the next Fetch_PC is 8'h10.
REQ-035 Queue full plus simultaneous Redirect_Valid (target 8'h20) and Fetch_Ready -> Fetch_Valid=0 next cycle, then Fetch_PC=8'h20.
REQ-036 PC=8'hFF with a non-jump word -> the next Fetch_PC after 8'hFF is 8'h00.
